// File: rtl/demux_pkg.sv
// demux_pkg: shared types for the two-way stream demultiplexer.
package demux_pkg;
    localparam int DATA_WIDTH_DEF = 32;
    typedef logic signed [DATA_WIDTH_DEF-1:0] data_t;
    typedef enum logic [1:0] {EMPTY, ONE, FULL} fill_t;
endpackage

// File: rtl/demux2_stream_fifo2.sv
// fifo2: 2-entry elastic buffer; head is registered so the consumer sees no combinational path.
module fifo2
    import demux_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);
    fill_t            r_fill;
    fill_t            w_fill_nxt;
    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [WIDTH-1:0] w_head_nxt;
    logic [WIDTH-1:0] w_tail_nxt;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push & (r_fill != FULL);
    assign w_pop   = i_pop & (r_fill != EMPTY);
    assign o_full  = r_fill == FULL;
    assign o_empty = r_fill == EMPTY;
    assign o_head  = r_head;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fill <= EMPTY;
            r_head <= '0;
            r_tail <= '0;
        end else begin
            r_fill <= w_fill_nxt;
            r_head <= w_head_nxt;
            r_tail <= w_tail_nxt;
        end
    end

    always_comb begin
        w_fill_nxt = r_fill;
        w_head_nxt = r_head;
        w_tail_nxt = r_tail;
        case (r_fill)
            EMPTY: if (w_push) begin
                w_fill_nxt = ONE;
                w_head_nxt = i_din;
            end
            ONE: begin
                // push and pop together keeps one entry: the new word becomes the head
                if (w_push && w_pop) w_head_nxt = i_din;
                else if (w_push) begin
                    w_fill_nxt = FULL;
                    w_tail_nxt = i_din;
                end else if (w_pop) w_fill_nxt = EMPTY;
            end
            FULL: if (w_pop) begin
                w_fill_nxt = ONE;
                w_head_nxt = r_tail;
            end
            default: w_fill_nxt = EMPTY;
        endcase
    end
endmodule

// File: rtl/demux2_stream.sv
// demux2_stream: steers a valid/ready word stream to one of two buffered outputs by select.
module demux2_stream
    import demux_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic [DATA_WIDTH-1:0] Din,
    input  logic                  Din_valid,
    input  logic                  select,
    output logic                  Din_ready,
    output logic [DATA_WIDTH-1:0] Dout0,
    output logic                  Dout0_valid,
    input  logic                  Dout0_ready,
    output logic [DATA_WIDTH-1:0] Dout1,
    output logic                  Dout1_valid,
    input  logic                  Dout1_ready,
    output logic [CNT_WIDTH-1:0]  Count0,
    output logic [CNT_WIDTH-1:0]  Count1
);
    logic                 w_full0;
    logic                 w_full1;
    logic                 w_empty0;
    logic                 w_empty1;
    logic                 w_acc;
    logic                 w_push0;
    logic                 w_push1;
    logic [CNT_WIDTH-1:0] r_cnt0;
    logic [CNT_WIDTH-1:0] r_cnt1;

    // ready depends only on registered fill levels, never on the consumers' ready
    assign Din_ready   = Reset_n & ~(select ? w_full1 : w_full0);
    assign w_acc       = Din_valid & Din_ready;
    assign w_push0     = w_acc & ~select;
    assign w_push1     = w_acc & select;
    assign Dout0_valid = ~w_empty0;
    assign Dout1_valid = ~w_empty1;
    assign Count0      = r_cnt0;
    assign Count1      = r_cnt1;

    fifo2 #(.WIDTH(DATA_WIDTH)) u_buf0 (
        .i_clk   (Clk),
        .i_rst_n (Reset_n),
        .i_push  (w_push0),
        .i_pop   (Dout0_ready),
        .i_din   (Din),
        .o_full  (w_full0),
        .o_empty (w_empty0),
        .o_head  (Dout0)
    );

    fifo2 #(.WIDTH(DATA_WIDTH)) u_buf1 (
        .i_clk   (Clk),
        .i_rst_n (Reset_n),
        .i_push  (w_push1),
        .i_pop   (Dout1_ready),
        .i_din   (Din),
        .o_full  (w_full1),
        .o_empty (w_empty1),
        .o_head  (Dout1)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_push0) r_cnt0 <= r_cnt0 + 1'b1;
            if (w_push1) r_cnt1 <= r_cnt1 + 1'b1;
        end
    end
endmodule
